x2050msarb: RTL

- Wishbone B4 pipelined arbiter placed between the main-store masters and the single storage slave (core RAM plus bump region).
- Master 0 is the CPU storage interface. Masters 1..NM-1 are channels.
- Channels take cycles ahead of the CPU, with a bounded-steal guard so the CPU is never starved.
- The block also rejects illegal addresses locally and times out a hung slave.

---
 rtl/x2050_pkg.sv | 21 ++
 rtl/x2050rrpick.sv | 33 +++
 rtl/x2050msarb.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/x2050_pkg.sv
// Shared definitions for the x2050 main-store arbiter.
//   AW, DW      : word address width and data width
//   BUMP_BASE   : lowest address bit that marks the bump region for the CPU
//   CH_LIMIT    : lowest address bit that marks storage above 32 MB
//   M_*         : master index assignments
//   arb_state_e : arbiter ownership state
package x2050_pkg;
  localparam int AW        = 30;
  localparam int DW        = 32;
  localparam int BUMP_BASE = 22;
  localparam int CH_LIMIT  = 23;
  localparam int M_CPU     = 0;
  localparam int M_MPX     = 1;
  localparam int M_SEL     = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_DRAIN
  } arb_state_e;
endpackage

// File: rtl/x2050rrpick.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index that has highest priority this round
//   gnt : one-hot winner, first set bit of req at or after ptr (circular);
//         all zero when req is empty
module x2050rrpick #(
  parameter int NM = 3,
  parameter int IW = 2
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] ptr,
  output logic [NM-1:0] gnt
);
  logic [2*NM-1:0] dbl, gdbl;
  logic [NM-1:0]   rot, rot_gnt;
  logic            found;

  // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
  always_comb begin
    dbl     = {req, req} >> ptr;
    rot     = dbl[NM-1:0];
    rot_gnt = '0;
    found   = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (!found && rot[i]) begin
        rot_gnt[i] = 1'b1;
        found      = 1'b1;
      end
    end
    gdbl = {rot_gnt, rot_gnt} << ptr;
    gnt  = gdbl[2*NM-1:NM];
  end
endmodule

// File: rtl/x2050msarb.sv
// Wishbone B4 pipelined arbiter in front of the main-store slave.
// Master 0 is the CPU, masters 1..NM-1 are channels. Channels win over the
// CPU, but at most MAXSTEAL times in a row while the CPU waits. Illegal
// addresses are answered locally with err; a slave that stops acking for
// TIMEOUT cycles is abandoned with an err to the owner.
// Ports:
//   i_clk, i_reset_n                 clock, async active-low reset
//   i_m_*                            per-master Wishbone requests (packed)
//   o_m_stall/ack/err, o_m_data      per-master responses, data broadcast
//   o_wb_*, i_wb_*                   slave side
//   o_grant                          one-hot owner, 0 when idle
//   o_busy                           any master owns the bus
module x2050msarb #(
  parameter int NM       = 3,
  parameter int AW       = x2050_pkg::AW,
  parameter int MAXSTEAL = 4,
  parameter int TIMEOUT  = 255,
  parameter int OW       = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic [NM-1:0]   i_m_cyc,
  input  logic [NM-1:0]   i_m_stb,
  input  logic [NM-1:0]   i_m_we,
  input  logic [NM*AW-1:0] i_m_addr,
  input  logic [NM*32-1:0] i_m_data,
  input  logic [NM*4-1:0] i_m_sel,
  output logic [NM-1:0]   o_m_stall,
  output logic [NM-1:0]   o_m_ack,
  output logic [NM-1:0]   o_m_err,
  output logic [31:0]     o_m_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [31:0]     o_wb_data,
  output logic [3:0]      o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [31:0]     i_wb_data,
  output logic [NM-1:0]   o_grant,
  output logic            o_busy
);
  import x2050_pkg::*;

  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = $clog2(MAXSTEAL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_e    state, state_nxt;
  logic [NM-1:0] grant, grant_nxt;
  logic [SW-1:0] steal, steal_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [OW-1:0] outst, outst_nxt;
  logic [TW-1:0] timer;
  logic          lerr_q;

  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_data;
  logic [3:0]    own_sel;
  logic          illegal, full, tmo, own_act, wb_stb, accept, dec;
  logic [NM-1:0] chan_req, pick;
  logic [IW-1:0] pick_idx;

  // Owner mux: grant is one-hot (or zero), so an AND-OR mux suffices.
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    own_sel  = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant[k]) begin
        own_cyc  = own_cyc | i_m_cyc[k];
        own_stb  = own_stb | i_m_stb[k];
        own_we   = own_we  | i_m_we[k];
        own_addr = own_addr | i_m_addr[k*AW +: AW];
        own_data = own_data | i_m_data[k*32 +: 32];
        own_sel  = own_sel  | i_m_sel[k*4 +: 4];
      end
    end
  end

  // The CPU may not touch the bump region; nobody may go above 32 MB.
  assign illegal = grant[M_CPU] ? (|own_addr[AW-1:BUMP_BASE])
                                : (|own_addr[AW-1:CH_LIMIT]);
  assign full    = &outst;
  assign tmo     = (state != ST_IDLE) && (timer == TW'(TIMEOUT));
  assign own_act = (state == ST_OWN) && own_cyc;
  assign wb_stb  = own_act & own_stb & ~illegal & ~full & ~tmo;
  assign accept  = wb_stb & ~i_wb_stall;
  assign dec     = (state != ST_IDLE) && (outst != '0) && (i_wb_ack | i_wb_err);

  always_comb begin
    outst_nxt = outst;
    if (tmo)                 outst_nxt = '0;
    else if (accept && !dec) outst_nxt = outst + OW'(1);
    else if (dec && !accept) outst_nxt = outst - OW'(1);
  end

  // Slave side. cyc stays up while responses are owed, even after the
  // owner has let go, and drops for the timeout cycle.
  assign o_wb_cyc  = ((state == ST_OWN && (own_cyc || outst != '0)) ||
                      state == ST_DRAIN) && !tmo;
  assign o_wb_stb  = wb_stb;
  assign o_wb_we   = own_we;
  assign o_wb_addr = own_addr;
  assign o_wb_data = own_data;
  assign o_wb_sel  = own_sel;
  assign o_m_data  = i_wb_data;

  // Illegal strobes are swallowed (never stalled) and answered via lerr_q.
  always_comb begin
    for (int k = 0; k < NM; k++) begin
      o_m_stall[k] = 1'b1;
      if (state == ST_OWN && grant[k])
        o_m_stall[k] = illegal ? 1'b0 : (i_wb_stall | full);
      o_m_ack[k] = grant[k] & own_act & i_wb_ack;
      o_m_err[k] = grant[k] & ((own_act & i_wb_err) | lerr_q | tmo);
    end
  end

  // Arbitration among channels only; the CPU is handled by the steal guard.
  assign chan_req = i_m_cyc & ~NM'(1);

  x2050rrpick #(.NM(NM), .IW(IW)) u_pick (
    .req(chan_req),
    .ptr(rr_ptr),
    .gnt(pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NM; k++)
      if (pick[k]) pick_idx = IW'(k);
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    steal_nxt  = steal;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (|chan_req && (!i_m_cyc[M_CPU] || steal < SW'(MAXSTEAL))) begin
          grant_nxt  = pick;
          rr_ptr_nxt = (pick_idx == IW'(NM-1)) ? IW'(1) : pick_idx + IW'(1);
          if (i_m_cyc[M_CPU]) steal_nxt = steal + SW'(1);
          state_nxt  = ST_OWN;
        end else if (i_m_cyc[M_CPU]) begin
          grant_nxt        = '0;
          grant_nxt[M_CPU] = 1'b1;
          steal_nxt        = '0;
          state_nxt        = ST_OWN;
        end
      end
      ST_OWN: begin
        if (tmo) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
        end else if (!own_cyc) begin
          if (outst == '0) begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (outst_nxt == '0) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      steal  <= '0;
      rr_ptr <= IW'(1);
      outst  <= '0;
      timer  <= '0;
      lerr_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      steal  <= steal_nxt;
      rr_ptr <= rr_ptr_nxt;
      outst  <= outst_nxt;
      timer  <= (tmo || outst == '0 || dec) ? '0 : timer + TW'(1);
      lerr_q <= own_act & own_stb & illegal;
    end
  end

  assign o_grant = grant;
  assign o_busy  = (state != ST_IDLE);
endmodule
